// File: rtl/sipo_rx_frame.sv
// Parametrised UART receive deserialiser: collects DATA_W accepted bit samples and strobes the word out.
// Optional parity checking is enabled by defining PARITY_CHECK_EN.
module sipo_rx_frame #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              i_baudclk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_shift,
    input  logic              i_onedetected,
    input  logic              i_zerodetected,
    input  logic              i_parity_odd,
    output logic [DATA_W-1:0] o_parallelout,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_bit_err,
    output logic              o_parity_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PARITY_CHECK_EN
    localparam logic [1:0] PARITY = 2'd2;
`endif

    logic [1:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] next_sr;
    logic              accept;
    logic              conflict;
    logic              last_bit;

    assign accept   = i_shift & (i_onedetected ^ i_zerodetected);
    assign conflict = i_shift & i_onedetected & i_zerodetected;
    assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

    // A one-bit word has no neighbours to shift, so the slice forms only exist for DATA_W > 1.
    generate
        if (DATA_W == 1) begin : g_w1
            assign next_sr = i_onedetected;
        end else if (MSB_FIRST) begin : g_msb
            assign next_sr = {shift_reg[DATA_W-2:0], i_onedetected};
        end else begin : g_lsb
            assign next_sr = {i_onedetected, shift_reg[DATA_W-1:1]};
        end
    endgenerate

`ifndef PARITY_CHECK_EN
    logic unused_parity_odd;
    assign unused_parity_odd = i_parity_odd;
`endif

    always_ff @(posedge i_baudclk) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            o_parallelout <= '0;
            o_valid       <= 1'b0;
            o_busy        <= 1'b0;
            o_bit_err     <= 1'b0;
            o_parity_err  <= 1'b0;
        end else begin
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_bit_err    <= conflict & (state != IDLE) & ~i_start;

            // A start pulse always wins: it opens a fresh frame and drops any sample on the same edge.
            if (i_start) begin
                state     <= SHIFT;
                bit_cnt   <= '0;
                shift_reg <= '0;
                o_busy    <= 1'b1;
            end else begin
                case (state)
                    SHIFT: begin
                        if (accept) begin
                            shift_reg <= next_sr;
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (last_bit) begin
`ifdef PARITY_CHECK_EN
                                state <= PARITY;
`else
                                o_parallelout <= next_sr;
                                o_valid       <= 1'b1;
                                o_busy        <= 1'b0;
                                state         <= IDLE;
`endif
                            end
                        end
                    end
`ifdef PARITY_CHECK_EN
                    PARITY: begin
                        if (accept) begin
                            o_parallelout <= shift_reg;
                            o_valid       <= 1'b1;
                            o_parity_err  <= i_onedetected != ((^shift_reg) ^ i_parity_odd);
                            o_busy        <= 1'b0;
                            state         <= IDLE;
                        end
                    end
`endif
                    default: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sipo_rx_frame.sv
// Directed bench for sipo_rx_frame: LSB-first, MSB-first, 5-bit and 1-bit instances share one stimulus stream.
// Parity sequences run only when PARITY_CHECK_EN is defined.
module tb_sipo_rx_frame;

    logic       i_baudclk = 1'b0;
    logic       i_rst_n;
    logic       i_start;
    logic       i_shift;
    logic       i_onedetected;
    logic       i_zerodetected;
    logic       i_parity_odd;

    logic [7:0] pout_lsb;
    logic [7:0] pout_msb;
    logic [4:0] pout_w5;
    logic [0:0] pout_w1;
    logic       valid_lsb, valid_msb, valid_w5, valid_w1;
    logic       busy_lsb, busy_msb, busy_w5, busy_w1;
    logic       berr_lsb, berr_msb, berr_w5, berr_w1;
    logic       perr_lsb, perr_msb, perr_w5, perr_w1;

    int checks   = 0;
    int failures = 0;
    int valid_cnt_lsb = 0, valid_cnt_msb = 0, valid_cnt_w5 = 0, valid_cnt_w1 = 0;
    int perr_cnt = 0;

    always #5 i_baudclk = ~i_baudclk;

    sipo_rx_frame #(.DATA_W(8), .MSB_FIRST(1'b0)) dut (
        .i_baudclk(i_baudclk), .i_rst_n(i_rst_n), .i_start(i_start), .i_shift(i_shift),
        .i_onedetected(i_onedetected), .i_zerodetected(i_zerodetected), .i_parity_odd(i_parity_odd),
        .o_parallelout(pout_lsb), .o_valid(valid_lsb), .o_busy(busy_lsb),
        .o_bit_err(berr_lsb), .o_parity_err(perr_lsb));

    sipo_rx_frame #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_msb (
        .i_baudclk(i_baudclk), .i_rst_n(i_rst_n), .i_start(i_start), .i_shift(i_shift),
        .i_onedetected(i_onedetected), .i_zerodetected(i_zerodetected), .i_parity_odd(i_parity_odd),
        .o_parallelout(pout_msb), .o_valid(valid_msb), .o_busy(busy_msb),
        .o_bit_err(berr_msb), .o_parity_err(perr_msb));

    sipo_rx_frame #(.DATA_W(5), .MSB_FIRST(1'b0)) dut_w5 (
        .i_baudclk(i_baudclk), .i_rst_n(i_rst_n), .i_start(i_start), .i_shift(i_shift),
        .i_onedetected(i_onedetected), .i_zerodetected(i_zerodetected), .i_parity_odd(i_parity_odd),
        .o_parallelout(pout_w5), .o_valid(valid_w5), .o_busy(busy_w5),
        .o_bit_err(berr_w5), .o_parity_err(perr_w5));

    sipo_rx_frame #(.DATA_W(1), .MSB_FIRST(1'b1)) dut_w1 (
        .i_baudclk(i_baudclk), .i_rst_n(i_rst_n), .i_start(i_start), .i_shift(i_shift),
        .i_onedetected(i_onedetected), .i_zerodetected(i_zerodetected), .i_parity_odd(i_parity_odd),
        .o_parallelout(pout_w1), .o_valid(valid_w1), .o_busy(busy_w1),
        .o_bit_err(berr_w1), .o_parity_err(perr_w1));

    // Pulse counters sampled mid-cycle so every one-cycle strobe is seen exactly once.
    always @(negedge i_baudclk) begin
        if (valid_lsb) valid_cnt_lsb++;
        if (valid_msb) valid_cnt_msb++;
        if (valid_w5)  valid_cnt_w5++;
        if (valid_w1)  valid_cnt_w1++;
        if (perr_lsb || perr_msb) perr_cnt++;
    end

    typedef struct {
        logic [7:0] bits;
        logic [7:0] exp_lsb;
        logic [7:0] exp_msb;
        logic [4:0] exp_w5;
        logic       exp_w1;
    } vec_t;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic shift, input logic one, input logic zero);
        i_start        = start;
        i_shift        = shift;
        i_onedetected  = one;
        i_zerodetected = zero;
        @(negedge i_baudclk);
    endtask

    task automatic sendBit(input logic v);
        applyStimulus(1'b0, 1'b1, v, ~v);
    endtask

    task automatic sendWord(input logic [7:0] w);
        for (int i = 0; i < 8; i++) sendBit(w[i]);
`ifdef PARITY_CHECK_EN
        sendBit(^w);
`endif
    endtask

    initial begin
        int v_lsb, v_msb, v_w5, v_w1, p0;

        vecs[0] = '{bits: 8'hA5, exp_lsb: 8'hA5, exp_msb: 8'hA5, exp_w5: 5'h05, exp_w1: 1'b1};
        vecs[1] = '{bits: 8'h01, exp_lsb: 8'h01, exp_msb: 8'h80, exp_w5: 5'h01, exp_w1: 1'b1};
        vecs[2] = '{bits: 8'h13, exp_lsb: 8'h13, exp_msb: 8'hC8, exp_w5: 5'h13, exp_w1: 1'b1};
        vecs[3] = '{bits: 8'hFF, exp_lsb: 8'hFF, exp_msb: 8'hFF, exp_w5: 5'h1F, exp_w1: 1'b1};
        vecs[4] = '{bits: 8'h0E, exp_lsb: 8'h0E, exp_msb: 8'h70, exp_w5: 5'h0E, exp_w1: 1'b0};

        i_rst_n = 1'b0;
        i_parity_odd = 1'b0;
        @(negedge i_baudclk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_pout", pout_lsb, 0);
        checkOutput("reset_valid", valid_lsb, 0);
        checkOutput("reset_busy", busy_lsb, 0);
        checkOutput("reset_bit_err", berr_lsb, 0);
        checkOutput("reset_parity_err", perr_lsb, 0);
        i_rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Table of whole frames
        for (int k = 0; k < 5; k++) begin
            v_lsb = valid_cnt_lsb; v_msb = valid_cnt_msb; v_w5 = valid_cnt_w5; v_w1 = valid_cnt_w1;
            p0 = perr_cnt;
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("v%0d_busy_start", k), busy_lsb, 1);
            sendWord(vecs[k].bits);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("v%0d_pout_lsb", k), pout_lsb, vecs[k].exp_lsb);
            checkOutput($sformatf("v%0d_pout_msb", k), pout_msb, vecs[k].exp_msb);
            checkOutput($sformatf("v%0d_pout_w5", k), pout_w5, vecs[k].exp_w5);
            checkOutput($sformatf("v%0d_pout_w1", k), pout_w1, vecs[k].exp_w1);
            checkOutput($sformatf("v%0d_valid_lsb", k), valid_cnt_lsb - v_lsb, 1);
            checkOutput($sformatf("v%0d_valid_msb", k), valid_cnt_msb - v_msb, 1);
            checkOutput($sformatf("v%0d_valid_w5", k), valid_cnt_w5 - v_w5, 1);
            checkOutput($sformatf("v%0d_valid_w1", k), valid_cnt_w1 - v_w1, 1);
            checkOutput($sformatf("v%0d_valid_low", k), valid_lsb, 0);
            checkOutput($sformatf("v%0d_busy_end", k), busy_lsb, 0);
            checkOutput($sformatf("v%0d_parity_err", k), perr_cnt - p0, 0);
        end

        // Reset in the middle of a frame discards the partial word
        v_lsb = valid_cnt_lsb; v_msb = valid_cnt_msb; v_w5 = valid_cnt_w5;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        sendBit(1'b1); sendBit(1'b1); sendBit(1'b1);
        i_rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        i_rst_n = 1'b1;
        checkOutput("midrst_pout", pout_lsb, 0);
        checkOutput("midrst_pout_msb", pout_msb, 0);
        checkOutput("midrst_busy", busy_lsb, 0);
        checkOutput("midrst_valid_lsb", valid_cnt_lsb - v_lsb, 0);
        checkOutput("midrst_valid_w5", valid_cnt_w5 - v_w5, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("midrst_busy_after", busy_lsb, 0);

        // Conflicting and empty samples mid-frame
        v_lsb = valid_cnt_lsb;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("conflict_bit_err", berr_lsb, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("conflict_bit_err_clear", berr_lsb, 0);
        checkOutput("conflict_busy", busy_lsb, 1);
        for (int i = 0; i < 4; i++) sendBit(1'b0);
`ifdef PARITY_CHECK_EN
        sendBit(1'b0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("conflict_pout", pout_lsb, 8'h0F);
        checkOutput("conflict_pout_msb", pout_msb, 8'hF0);
        checkOutput("conflict_pout_w5", pout_w5, 5'h0F);
        checkOutput("conflict_valid", valid_cnt_lsb - v_lsb, 1);

        // Restart part-way through a frame
        v_lsb = valid_cnt_lsb; v_w5 = valid_cnt_w5;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) sendBit(1'b1);
`ifdef PARITY_CHECK_EN
        sendBit(1'b0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("restart_pout", pout_lsb, 8'hFF);
        checkOutput("restart_pout_w5", pout_w5, 5'h1F);
        checkOutput("restart_valid", valid_cnt_lsb - v_lsb, 1);
        checkOutput("restart_valid_w5", valid_cnt_w5 - v_w5, 1);

`ifdef PARITY_CHECK_EN
        // Even parity on 0x07: a 1 parity bit is correct, a 0 is an error
        i_parity_odd = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) sendBit(i < 3);
        sendBit(1'b1);
        checkOutput("par_ok_valid", valid_lsb, 1);
        checkOutput("par_ok_err", perr_lsb, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) sendBit(i < 3);
        sendBit(1'b0);
        checkOutput("par_bad_valid", valid_lsb, 1);
        checkOutput("par_bad_err", perr_lsb, 1);
        checkOutput("par_bad_pout", pout_lsb, 8'h07);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("par_bad_err_clear", perr_lsb, 0);
`else
        checkOutput("parity_err_tied", perr_lsb, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
